// File: rtl/key_fifo_console_pkg.sv
// key_fifo_console_pkg: shared mode and press-event encodings for the FIFO console
package key_fifo_console_pkg;
  typedef enum logic [1:0] {MODE_WR = 2'd0, MODE_RD = 2'd1, MODE_AUTO = 2'd2} mode_e;
  typedef enum logic [1:0] {EV_NONE = 2'd0, EV_SINGLE = 2'd1, EV_DOUBLE = 2'd2} event_e;
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_WR: return MODE_RD;
      MODE_RD: return MODE_AUTO;
      default: return MODE_WR;
    endcase
  endfunction
endpackage

// File: rtl/key_fifo_console_press_classifier.sv
// key_fifo_console_press_classifier: splits command key presses into single/double events
module key_fifo_console_press_classifier
  import key_fifo_console_pkg::*;
#(
  parameter int CNT_DBL = 3_600_000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   cmd_pulse_i,
  output event_e event_o,
  output logic   pending_o
);
  localparam int CW = $clog2(CNT_DBL);
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // A press landing in the expiry cycle still wins as a double.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    event_o = EV_NONE;
    if (state_q == S_IDLE) begin
      if (cmd_pulse_i) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    end else if (cmd_pulse_i) begin
      state_d = S_IDLE;
      event_o = EV_DOUBLE;
    end else if (cnt_q == CW'(CNT_DBL - 1)) begin
      state_d = S_IDLE;
      event_o = EV_SINGLE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  assign pending_o = state_q == S_WAIT;
endmodule

// File: rtl/key_fifo_console.sv
// key_fifo_console: push-button front end driving a registered-read FIFO in WR/RD/AUTO modes
module key_fifo_console
  import key_fifo_console_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int CNT_DBL    = 3_600_000,
  parameter  int CNT_AUTO   = 6_000_000,
  localparam int IW         = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit1_pulse_i,
  input  logic                  bit0_pulse_i,
  input  logic                  cmd_pulse_i,
  input  logic                  full_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic [IW-1:0]         bit_idx_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [1:0]            mode_o,
  output logic                  paused_o,
  output logic                  ovf_o,
  output logic                  udf_o,
  output logic                  pending_o
);
  localparam int AW = $clog2(CNT_AUTO);
  event_e ev;
  mode_e mode_q, mode_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, dout_q, dout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] tmr_q, tmr_d;
  logic wr_q, wr_d, rd_q, rd_d, cap_q, ovf_q, ovf_d, udf_q, udf_d, pau_q, pau_d;
  logic single, dbl, bit_ev, auto_run, auto_tick;
  key_fifo_console_press_classifier #(.CNT_DBL(CNT_DBL)) u_press_classifier (
    .clk         (clk),
    .rst         (rst),
    .cmd_pulse_i (cmd_pulse_i),
    .event_o     (ev),
    .pending_o   (pending_o)
  );
  assign single    = ev == EV_SINGLE;
  assign dbl       = ev == EV_DOUBLE;
  assign bit_ev    = mode_q == MODE_WR && (bit1_pulse_i ^ bit0_pulse_i);
  assign auto_run  = mode_q == MODE_AUTO && !pau_q;
  assign auto_tick = auto_run && tmr_q == AW'(CNT_AUTO - 1);
  always_comb begin
    mode_d = dbl ? next_mode(mode_q) : mode_q;
    din_d  = din_q;
    if (bit_ev) din_d[idx_q] = bit1_pulse_i;
    wr_d   = single && mode_q == MODE_WR && !full_i;
    rd_d   = ((single && mode_q == MODE_RD) || auto_tick) && !empty_i;
    idx_d  = wr_d ? '0 : bit_ev ? (idx_q == IW'(DATA_WIDTH - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    ovf_d  = dbl ? 1'b0 : ovf_q | (single && mode_q == MODE_WR && full_i);
    udf_d  = dbl ? 1'b0 : udf_q | (single && mode_q == MODE_RD && empty_i);
    pau_d  = dbl ? 1'b0 : pau_q ^ (single && mode_q == MODE_AUTO);
    tmr_d  = dbl ? '0 : auto_run ? (auto_tick ? '0 : tmr_q + AW'(1)) : tmr_q;
    dout_d = cap_q ? rd_data_i : dout_q;
  end
  // cap_q marks the cycle the FIFO presents the word requested by the previous rd_en.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mode_q <= MODE_WR;
      din_q  <= '0;
      dout_q <= '0;
      idx_q  <= '0;
      tmr_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cap_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      pau_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      din_q  <= din_d;
      dout_q <= dout_d;
      idx_q  <= idx_d;
      tmr_q  <= tmr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cap_q  <= rd_q;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      pau_q  <= pau_d;
    end
  assign wr_en_o   = wr_q;
  assign rd_en_o   = rd_q;
  assign wr_data_o = din_q;
  assign din_o     = din_q;
  assign bit_idx_o = idx_q;
  assign dout_o    = dout_q;
  assign mode_o    = mode_q;
  assign paused_o  = pau_q;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;
endmodule

// File: tb/tb_key_fifo_console.sv
// tb_key_fifo_console: directed checks of key_fifo_console against an 8-deep registered-read FIFO
module tb_key_fifo_console;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit1, bit0, cmd, full, empty, wr_en, rd_en, paused, ovf, udf, pending;
  logic [DW-1:0] rd_data, wr_data, din, dout;
  logic [2:0] bit_idx;
  logic [1:0] mode;
  logic [DW-1:0] mem [8];
  int wp, rp, cnt;
  int n_chk, n_pass, cyc, t0, hits;
  always #5 clk = ~clk;
  key_fifo_console #(.DATA_WIDTH(DW), .CNT_DBL(4), .CNT_AUTO(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .bit1_pulse_i (bit1),
    .bit0_pulse_i (bit0),
    .cmd_pulse_i  (cmd),
    .full_i       (full),
    .empty_i      (empty),
    .rd_data_i    (rd_data),
    .wr_en_o      (wr_en),
    .rd_en_o      (rd_en),
    .wr_data_o    (wr_data),
    .din_o        (din),
    .bit_idx_o    (bit_idx),
    .dout_o       (dout),
    .mode_o       (mode),
    .paused_o     (paused),
    .ovf_o        (ovf),
    .udf_o        (udf),
    .pending_o    (pending)
  );
  assign full  = cnt == 8;
  assign empty = cnt == 0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= 0;
      rp <= 0;
      cnt <= 0;
      rd_data <= '0;
    end else if (wr_en && !full) begin
      mem[wp] <= wr_data;
      wp <= (wp + 1) % 8;
      cnt <= cnt + 1;
    end else if (rd_en && !empty) begin
      rd_data <= mem[rp];
      rp <= (rp + 1) % 8;
      cnt <= cnt - 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask
  task automatic press_cmd();
    cmd = 1'b1;
    step();
    cmd = 1'b0;
  endtask
  task automatic enter_bit(input logic b);
    if (b) bit1 = 1'b1;
    else bit0 = 1'b1;
    step();
    bit1 = 1'b0;
    bit0 = 1'b0;
  endtask
  task automatic single_watch(input logic ew, input logic er, input int n);
    int t;
    t = cyc;
    press_cmd();
    while (cyc - t <= n) begin
      chk("wr_en", 32'(wr_en), 32'(ew && cyc - t == 5));
      chk("rd_en", 32'(rd_en), 32'(er && cyc - t == 5));
      step();
    end
  endtask
  task automatic put_word(input logic [7:0] v);
    for (int i = 0; i < 8; i++) enter_bit(v[i]);
    chk("din_word", 32'(din), 32'(v));
    single_watch(1'b1, 1'b0, 6);
  endtask
  initial begin
    bit1 = 1'b0;
    bit0 = 1'b0;
    cmd = 1'b0;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    repeat (3) step();
    chk("rst_mode", 32'(mode), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_bit_idx", 32'(bit_idx), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);
    chk("rst_paused", 32'(paused), 0);
    chk("rst_pending", 32'(pending), 0);
    rst = 1'b1;
    step();
    bit1 = 1'b1;
    bit0 = 1'b1;
    step();
    bit1 = 1'b0;
    bit0 = 1'b0;
    chk("both_bits_idx", 32'(bit_idx), 0);
    chk("both_bits_din", 32'(din), 0);
    enter_bit(1'b1);
    enter_bit(1'b0);
    enter_bit(1'b1);
    chk("partial_idx", 32'(bit_idx), 3);
    chk("partial_din", 32'(din), 'h05);
    enter_bit(1'b1);
    enter_bit(1'b0);
    enter_bit(1'b0);
    enter_bit(1'b1);
    enter_bit(1'b0);
    chk("wrap_idx", 32'(bit_idx), 0);
    chk("word_din", 32'(din), 'h4D);
    t0 = cyc;
    press_cmd();
    while (cyc - t0 <= 6) begin
      chk("first_wr_en", 32'(wr_en), 32'(cyc - t0 == 5));
      if (cyc - t0 == 1) chk("pending_wait", 32'(pending), 1);
      if (cyc - t0 == 5) chk("wr_data", 32'(wr_data), 'h4D);
      step();
    end
    chk("post_wr_idx", 32'(bit_idx), 0);
    chk("post_wr_din", 32'(din), 'h4D);
    repeat (7) single_watch(1'b1, 1'b0, 6);
    chk("fifo_full_cnt", 32'(cnt), 8);
    chk("ovf_before", 32'(ovf), 0);
    single_watch(1'b0, 1'b0, 6);
    chk("ovf_set", 32'(ovf), 1);
    chk("no_write_when_full", 32'(cnt), 8);
    press_cmd();
    press_cmd();
    chk("dbl_mode_rd", 32'(mode), 1);
    chk("dbl_ovf_clr", 32'(ovf), 0);
    chk("dbl_pending", 32'(pending), 0);
    t0 = cyc;
    press_cmd();
    while (cyc - t0 <= 7) begin
      chk("first_rd_en", 32'(rd_en), 32'(cyc - t0 == 5));
      if (cyc - t0 == 6) chk("dout_early", 32'(dout), 0);
      if (cyc - t0 == 7) chk("dout_rd", 32'(dout), 'h4D);
      step();
    end
    repeat (7) single_watch(1'b0, 1'b1, 7);
    chk("fifo_drained", 32'(empty), 1);
    single_watch(1'b0, 1'b0, 7);
    chk("udf_set", 32'(udf), 1);
    press_cmd();
    repeat (3) step();
    press_cmd();
    chk("expiry_dbl_mode", 32'(mode), 2);
    chk("expiry_dbl_udf", 32'(udf), 0);
    chk("expiry_dbl_pending", 32'(pending), 0);
    repeat (6) begin
      chk("auto_empty_rd_en", 32'(rd_en), 0);
      chk("auto_empty_udf", 32'(udf), 0);
      step();
    end
    t0 = cyc;
    press_cmd();
    while (cyc - t0 < 5) step();
    chk("single_a_paused", 32'(paused), 1);
    chk("single_a_idle", 32'(pending), 0);
    press_cmd();
    while (cyc - t0 < 10) step();
    chk("single_b_paused", 32'(paused), 0);
    chk("single_b_mode", 32'(mode), 2);
    press_cmd();
    press_cmd();
    chk("dbl_mode_wr", 32'(mode), 0);
    chk("dbl_keeps_din", 32'(din), 'h4D);
    chk("dbl_keeps_dout", 32'(dout), 'h4D);
    put_word(8'hA5);
    put_word(8'h3C);
    put_word(8'h81);
    press_cmd();
    press_cmd();
    press_cmd();
    t0 = cyc;
    press_cmd();
    chk("auto_mode", 32'(mode), 2);
    while (cyc - t0 < 9) begin
      chk("auto_rd_en", 32'(rd_en), 32'(cyc - t0 == 6));
      chk("auto_dout", 32'(dout), cyc - t0 < 8 ? 'h4D : 'hA5);
      step();
    end
    press_cmd();
    while (cyc - t0 < 14) begin
      chk("auto_rd_en", 32'(rd_en), 32'(cyc - t0 == 11));
      chk("auto_dout", 32'(dout), cyc - t0 < 13 ? 'hA5 : 'h3C);
      step();
    end
    while (cyc - t0 < 34) begin
      chk("paused_rd_en", 32'(rd_en), 0);
      chk("paused_flag", 32'(paused), 1);
      step();
    end
    press_cmd();
    hits = 0;
    while (cyc - t0 < 46) begin
      hits += int'(rd_en);
      step();
    end
    chk("resume_pops", 32'(hits), 1);
    chk("resume_paused", 32'(paused), 0);
    chk("resume_dout", 32'(dout), 'h81);
    chk("auto_drained", 32'(empty), 1);
    repeat (12) begin
      chk("auto_empty_rd_en", 32'(rd_en), 0);
      chk("auto_empty_udf", 32'(udf), 0);
      step();
    end
    press_cmd();
    press_cmd();
    chk("back_to_wr", 32'(mode), 0);
    press_cmd();
    step();
    chk("mid_wait_pending", 32'(pending), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_din", 32'(din), 0);
    chk("async_rst_dout", 32'(dout), 0);
    step();
    rst = 1'b1;
    repeat (6) begin
      chk("discarded_wr_en", 32'(wr_en), 0);
      chk("discarded_pending", 32'(pending), 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
